// File: rtl/wb_led_sweeper.sv
// Wishbone-slave LED sweeper: one lit LED walks across NLEDS outputs in one of
// four modes (one-shot bounce, continuous bounce, wrap, one-shot sweep).
//
// Ports:
//   i_clk, i_reset            clock, synchronous active-high reset
//   i_wb_cyc/stb/we/addr/data Wishbone request (addr 0 CTRL, 1 DIV, 2 STATUS, 3 LED)
//   o_wb_stall/ack/data       Wishbone response
//   o_led                     LED drive, bit 0 = position 0
//   o_busy                    sweep in progress
module wb_led_sweeper #(
  parameter int NLEDS       = 8,
  parameter int DIV_W       = 24,
  parameter int DEFAULT_DIV = 1
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_wb_cyc,
  input  logic             i_wb_stb,
  input  logic             i_wb_we,
  input  logic [1:0]       i_wb_addr,
  input  logic [31:0]      i_wb_data,
  output logic             o_wb_stall,
  output logic             o_wb_ack,
  output logic [31:0]      o_wb_data,
  output logic [NLEDS-1:0] o_led,
  output logic             o_busy
);

  localparam int PW = $clog2(NLEDS);
  localparam logic [PW-1:0] TOP = PW'(NLEDS - 1);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t           state_q, state_d;
  logic [PW-1:0]    pos_q, pos_d;
  logic             dir_q, dir_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] reload;
  logic [1:0]       mode_q, mode_d;
  logic [NLEDS-1:0] led_q, led_d;
  logic             ack_q, ack_d;
  logic [31:0]      rdat_q, rdat_d;
  logic             busy, accept, wr, rd;

  assign busy   = (state_q == S_RUN);
  assign o_busy = busy;

  // Only requests that would disturb a running sweep are held off.
  assign o_wb_stall = busy & i_wb_stb & i_wb_we &
                      (((i_wb_addr == 2'd0) & ~i_wb_data[31]) |
                       (i_wb_addr == 2'd3));

  assign accept = i_wb_cyc & i_wb_stb & ~o_wb_stall;
  assign wr     = accept & i_wb_we;
  assign rd     = accept & ~i_wb_we;

  // A DIV of 0 behaves as 1: hold for a single clock.
  assign reload = (div_q == '0) ? '0 : div_q - 1'b1;

  assign o_led     = busy ? (NLEDS'(1) << pos_q) : led_q;
  // Dropping the cycle abandons an ack still in flight.
  assign o_wb_ack  = ack_q & i_wb_cyc;
  assign o_wb_data = rdat_q;

  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    dir_d   = dir_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    mode_d  = mode_q;
    led_d   = led_q;
    rdat_d  = rdat_q;
    ack_d   = accept;

    if (busy) begin
      if (cnt_q != '0) begin
        cnt_d = cnt_q - 1'b1;
      end else begin
        cnt_d = reload;
        unique case (mode_q)
          2'd0, 2'd1: begin
            if (!dir_q) begin
              // Turn at the top without repeating it.
              if (pos_q == TOP) begin
                pos_d = TOP - 1'b1;
                dir_d = 1'b1;
              end else begin
                pos_d = pos_q + 1'b1;
              end
            end else if (pos_q != '0) begin
              pos_d = pos_q - 1'b1;
            end else if (mode_q == 2'd0) begin
              state_d = S_IDLE;
              led_d   = '0;
            end else begin
              pos_d = PW'(1);
              dir_d = 1'b0;
            end
          end
          2'd2: begin
            pos_d = (pos_q == TOP) ? '0 : pos_q + 1'b1;
          end
          default: begin
            if (pos_q == TOP) begin
              state_d = S_IDLE;
              led_d   = '0;
            end else begin
              pos_d = pos_q + 1'b1;
            end
          end
        endcase
      end
    end

    if (wr) begin
      unique case (i_wb_addr)
        2'd0: begin
          mode_d = i_wb_data[2:1];
          if (i_wb_data[31]) begin
            if (busy) begin
              state_d = S_IDLE;
              led_d   = '0;
            end
          end else if (i_wb_data[0] && !busy) begin
            state_d = S_RUN;
            pos_d   = '0;
            dir_d   = 1'b0;
            cnt_d   = reload;
          end
        end
        2'd1: div_d = i_wb_data[DIV_W-1:0];
        2'd3: if (!busy) led_d = i_wb_data[NLEDS-1:0];
        default: ;
      endcase
    end

    if (rd) begin
      unique case (i_wb_addr)
        2'd0: rdat_d = {30'b0, mode_q};
        2'd1: rdat_d = 32'(div_q);
        2'd2: rdat_d = {dir_q, 15'b0, 8'(pos_q), 7'b0, busy};
        default: rdat_d = 32'(o_led);
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= S_IDLE;
      pos_q   <= '0;
      dir_q   <= 1'b0;
      cnt_q   <= '0;
      div_q   <= DIV_W'(DEFAULT_DIV);
      mode_q  <= 2'd0;
      led_q   <= '0;
      ack_q   <= 1'b0;
      rdat_q  <= '0;
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
      dir_q   <= dir_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      mode_q  <= mode_d;
      led_q   <= led_d;
      ack_q   <= ack_d;
      rdat_q  <= rdat_d;
    end
  end

endmodule

// File: tb/tb_wb_led_sweeper.sv
// Directed testbench for wb_led_sweeper (NLEDS=6).
// Each task drives one scenario and checks its own results.
module tb_wb_led_sweeper;

  logic        clk = 1'b0;
  logic        rst;
  logic        cyc, stb, we;
  logic [1:0]  addr;
  logic [31:0] wdat;
  logic        stall, ack;
  logic [31:0] rdat;
  logic [5:0]  led;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  wb_led_sweeper #(
    .NLEDS(6),
    .DIV_W(24),
    .DEFAULT_DIV(1)
  ) dut (
    .i_clk(clk),
    .i_reset(rst),
    .i_wb_cyc(cyc),
    .i_wb_stb(stb),
    .i_wb_we(we),
    .i_wb_addr(addr),
    .i_wb_data(wdat),
    .o_wb_stall(stall),
    .o_wb_ack(ack),
    .o_wb_data(rdat),
    .o_led(led),
    .o_busy(busy)
  );

  task automatic wb_write(input logic [1:0] a, input logic [31:0] d);
    cyc = 1; stb = 1; we = 1; addr = a; wdat = d;
    @(posedge clk); #1;
    cyc = 0; stb = 0; we = 0;
  endtask

  task automatic wb_read(input logic [1:0] a, output logic [31:0] d,
                         output logic k);
    cyc = 1; stb = 1; we = 0; addr = a;
    @(posedge clk); #1;
    d = rdat; k = ack;
    cyc = 0; stb = 0;
  endtask

  task automatic test_reset;
    logic [31:0] d;
    logic k;
    n_cmp++;
    if (led !== 6'h00 || busy !== 1'b0 || ack !== 1'b0 || rdat !== 32'h0) begin
      n_err++;
      $display("FAIL reset_out: led=%h busy=%b ack=%b data=%h want 00 0 0 0",
               led, busy, ack, rdat);
    end
    wb_read(2'd1, d, k);
    n_cmp++;
    if (k !== 1'b1 || d !== 32'h1) begin
      n_err++;
      $display("FAIL reset_div: ack=%b data=%h want 1 00000001", k, d);
    end
    wb_read(2'd2, d, k);
    n_cmp++;
    if (d !== 32'h0) begin
      n_err++;
      $display("FAIL reset_status: got %h want 00000000", d);
    end
  endtask

  task automatic test_oneshot;
    logic [5:0] ev [11] = '{6'h01, 6'h02, 6'h04, 6'h08, 6'h10, 6'h20,
                            6'h10, 6'h08, 6'h04, 6'h02, 6'h01};
    wb_write(2'd0, 32'h1);
    for (int i = 0; i < 11; i++) begin
      if (i > 0) begin @(posedge clk); #1; end
      n_cmp++;
      if (led !== ev[i] || busy !== 1'b1) begin
        n_err++;
        $display("FAIL oneshot[%0d]: led=%h busy=%b want %h 1",
                 i, led, busy, ev[i]);
      end
    end
    @(posedge clk); #1;
    n_cmp++;
    if (led !== 6'h00 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL oneshot_end: led=%h busy=%b want 00 0", led, busy);
    end
  endtask

  task automatic test_bounce;
    logic [5:0] ev [13] = '{6'h01, 6'h02, 6'h04, 6'h08, 6'h10, 6'h20,
                            6'h10, 6'h08, 6'h04, 6'h02, 6'h01, 6'h02,
                            6'h04};
    wb_write(2'd0, 32'h3);
    for (int i = 0; i < 13; i++) begin
      if (i > 0) begin @(posedge clk); #1; end
      n_cmp++;
      if (led !== ev[i]) begin
        n_err++;
        $display("FAIL bounce[%0d]: led=%h want %h", i, led, ev[i]);
      end
    end
    // STOP together with START: stop must win
    wb_write(2'd0, 32'h8000_0001);
    n_cmp++;
    if (led !== 6'h00 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL stop_start: led=%h busy=%b want 00 0", led, busy);
    end
  endtask

  task automatic test_wrap_div3;
    logic [5:0] e;
    wb_write(2'd1, 32'd3);
    wb_write(2'd0, 32'h5);
    for (int k = 0; k < 8; k++) begin
      e = 6'h01 << (k % 6);
      for (int h = 0; h < 3; h++) begin
        if (k > 0 || h > 0) begin @(posedge clk); #1; end
        n_cmp++;
        if (led !== e) begin
          n_err++;
          $display("FAIL wrap[%0d.%0d]: led=%h want %h", k, h, led, e);
        end
      end
    end
    cyc = 1; stb = 1; we = 1; addr = 2'd0; wdat = 32'h8000_0000;
    #1;
    n_cmp++;
    if (stall !== 1'b0) begin
      n_err++;
      $display("FAIL stop_stall: got %b want 0", stall);
    end
    @(posedge clk); #1;
    cyc = 0; stb = 0; we = 0;
    n_cmp++;
    if (led !== 6'h00 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL stop: led=%h busy=%b want 00 0", led, busy);
    end
  endtask

  task automatic test_stall;
    bit done;
    wb_write(2'd0, 32'h7);
    cyc = 1; stb = 1; we = 1; addr = 2'd0; wdat = 32'h1;
    #1;
    n_cmp++;
    if (stall !== 1'b1) begin
      n_err++;
      $display("FAIL start_stall: got %b want 1", stall);
    end
    repeat (4) @(posedge clk);
    #1;
    we = 0; addr = 2'd2;
    #1;
    n_cmp++;
    if (stall !== 1'b0) begin
      n_err++;
      $display("FAIL read_stall: got %b want 0", stall);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (ack !== 1'b1 || rdat !== 32'h0000_0101) begin
      n_err++;
      $display("FAIL status_busy: ack=%b data=%h want 1 00000101", ack, rdat);
    end
    we = 1; addr = 2'd0; wdat = 32'h1;
    done = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      #1;
      if (stall === 1'b0) done = 1;
      else begin @(posedge clk); #1; end
    end
    n_cmp++;
    if (!done || busy !== 1'b0 || led !== 6'h00) begin
      n_err++;
      $display("FAIL stall_release: done=%b busy=%b led=%h want 1 0 00",
               done, busy, led);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (ack !== 1'b1 || busy !== 1'b1 || led !== 6'h01) begin
      n_err++;
      $display("FAIL restart: ack=%b busy=%b led=%h want 1 1 01",
               ack, busy, led);
    end
    cyc = 0; stb = 0; we = 0;
    wb_write(2'd0, 32'h8000_0000);
  endtask

  task automatic test_div;
    logic [31:0] d;
    logic k;
    logic [5:0] ev [8] = '{6'h01, 6'h01, 6'h02, 6'h02, 6'h02,
                           6'h02, 6'h02, 6'h04};
    wb_write(2'd1, 32'd0);
    wb_read(2'd1, d, k);
    n_cmp++;
    if (d !== 32'h0) begin
      n_err++;
      $display("FAIL div0_read: got %h want 00000000", d);
    end
    wb_write(2'd0, 32'h5);
    for (int i = 0; i < 3; i++) begin
      if (i > 0) begin @(posedge clk); #1; end
      n_cmp++;
      if (led !== (6'h01 << i)) begin
        n_err++;
        $display("FAIL div0_step[%0d]: led=%h want %h", i, led, 6'h01 << i);
      end
    end
    wb_write(2'd0, 32'h8000_0000);
    wb_write(2'd1, 32'd3);
    wb_write(2'd0, 32'h5);
    // this write is accepted one clock into the 3-clock hold of position 0
    wb_write(2'd1, 32'd5);
    for (int i = 0; i < 8; i++) begin
      if (i > 0) begin @(posedge clk); #1; end
      n_cmp++;
      if (led !== ev[i]) begin
        n_err++;
        $display("FAIL div5[%0d]: led=%h want %h", i, led, ev[i]);
      end
    end
    wb_write(2'd0, 32'h8000_0000);
  endtask

  task automatic test_led_reset;
    logic [31:0] d;
    logic k;
    wb_write(2'd3, 32'hA5);
    n_cmp++;
    if (led !== 6'h25) begin
      n_err++;
      $display("FAIL led_write: got %h want 25", led);
    end
    wb_read(2'd3, d, k);
    n_cmp++;
    if (k !== 1'b1 || d !== 32'h25) begin
      n_err++;
      $display("FAIL led_read: ack=%b data=%h want 1 00000025", k, d);
    end
    wb_write(2'd0, 32'h5);
    n_cmp++;
    if (led !== 6'h01) begin
      n_err++;
      $display("FAIL led_override: got %h want 01", led);
    end
    repeat (3) @(posedge clk);
    #1;
    rst = 1; cyc = 1; stb = 1; we = 0; addr = 2'd2;
    @(posedge clk); #1;
    n_cmp++;
    if (led !== 6'h00 || busy !== 1'b0 || ack !== 1'b0 || rdat !== 32'h0) begin
      n_err++;
      $display("FAIL mid_reset: led=%h busy=%b ack=%b data=%h want 00 0 0 0",
               led, busy, ack, rdat);
    end
    rst = 0; cyc = 0; stb = 0;
    wb_read(2'd1, d, k);
    n_cmp++;
    if (d !== 32'h1) begin
      n_err++;
      $display("FAIL reset_div2: got %h want 00000001", d);
    end
  endtask

  task automatic test_abort;
    cyc = 1; stb = 1; we = 0; addr = 2'd2;
    @(posedge clk); #1;
    cyc = 0; stb = 0;
    #1;
    n_cmp++;
    if (ack !== 1'b0) begin
      n_err++;
      $display("FAIL abort_ack: got %b want 0", ack);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (ack !== 1'b0) begin
      n_err++;
      $display("FAIL abort_ack2: got %b want 0", ack);
    end
  endtask

  initial begin
    rst = 1; cyc = 0; stb = 0; we = 0; addr = 2'd0; wdat = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    test_reset();
    test_oneshot();
    test_bounce();
    test_wrap_div3();
    test_stall();
    test_div();
    test_led_reset();
    test_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
